uart_cmd_ctrl: RTL and testbench

Frame-level controller sitting behind `uart_rx` and in front of `uart_tx`. Sequences received bytes through a 4-byte command frame (sync, address, value, checksum), writes an 8×8-bit register bank on a valid frame, and answers every complete frame with a one-byte ACK/NAK over the shared transmitter. Includes an inter-byte timeout so a truncated frame cannot wedge the parser.

---
 rtl/uart_cmd_ctrl_pkg.sv | 10 +
 rtl/uart_cmd_ctrl_timeout_cnt.sv | 17 +
 rtl/uart_cmd_ctrl.sv | 81 ++++++++
 tb/tb_uart_cmd_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg: frame constants, parser states and checksum helper
package uart_cmd_ctrl_pkg;
   localparam logic [7:0] SYNC = 8'hAA;
   localparam logic [7:0] ACK  = 8'h06;
   localparam logic [7:0] NAK  = 8'h15;
   typedef enum logic [2:0] {IDLE, GOT_SYNC, GOT_ADDR, GOT_VAL, EXEC, RESP} state_t;
   function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] value);
      return SYNC + addr + value;
   endfunction
endpackage

// File: rtl/uart_cmd_ctrl_timeout_cnt.sv
// timeout_cnt: inter-byte watchdog, pulses expired when TIMEOUT cycles pass without clr
module timeout_cnt #(
   parameter int TIMEOUT = 1200000
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT);
   logic [W-1:0] cnt;
   assign expired = en && cnt == W'(TIMEOUT - 1);
   always_ff @(posedge clk)
      if (!rstn || clr || expired) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses 4-byte command frames, writes an 8x8 register bank and replies ACK/NAK
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 1200000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rcv,
   input  logic [7:0]  data,
   input  logic        tx_ready,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic [63:0] regs,
   output logic        frame_ok,
   output logic        err
);
   state_t state, state_d;
   logic [7:0] addr, addr_d, value, value_d;
   logic ok_d, err_d, start_d, expired, in_frame, chk_good;
   assign in_frame = state == GOT_SYNC || state == GOT_ADDR || state == GOT_VAL;
   assign chk_good = data == frame_chk(addr, value) && addr[7:3] == 5'd0;
   timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk(clk), .rstn(rstn), .clr(rcv || !in_frame), .en(in_frame), .expired(expired)
   );
   // verdict is decided as CHK arrives so frame_ok/err are registered yet high during EXEC
   always_comb begin
      state_d = state;
      addr_d  = addr;
      value_d = value;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      start_d = 1'b0;
      case (state)
         IDLE:     state_d = rcv && data == SYNC ? GOT_SYNC : IDLE;
         GOT_SYNC: begin
            addr_d  = rcv ? data : addr;
            state_d = rcv ? GOT_ADDR : expired ? IDLE : GOT_SYNC;
            err_d   = !rcv && expired;
         end
         GOT_ADDR: begin
            value_d = rcv ? data : value;
            state_d = rcv ? GOT_VAL : expired ? IDLE : GOT_ADDR;
            err_d   = !rcv && expired;
         end
         GOT_VAL:  begin
            state_d = rcv ? EXEC : expired ? IDLE : GOT_VAL;
            ok_d    = rcv && chk_good;
            err_d   = rcv ? !chk_good : expired;
         end
         EXEC:     state_d = RESP;
         RESP:     begin
            start_d = tx_ready;
            state_d = tx_ready ? IDLE : RESP;
         end
         default:  state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!rstn) begin
         state    <= IDLE;
         addr     <= '0;
         value    <= '0;
         regs     <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         frame_ok <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_d;
         addr     <= addr_d;
         value    <= value_d;
         tx_start <= start_d;
         frame_ok <= ok_d;
         err      <= err_d;
         if (state == EXEC) begin
            tx_data <= frame_ok ? ACK : NAK;
            if (frame_ok) regs[{addr[2:0], 3'b000} +: 8] <= value;
         end
      end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: randomized frame stimulus checked against a frame-level reference model
module tb_uart_cmd_ctrl;
   localparam int TO = 100;
   logic clk = 1'b0, rstn = 1'b0, rcv = 1'b0, tx_ready = 1'b1;
   logic [7:0] data = 8'h00;
   logic tx_start, frame_ok, err;
   logic [7:0] tx_data;
   logic [63:0] regs;
   int n_tests = 0, n_fail = 0;
   int n_ok = 0, n_err = 0, n_start = 0, e_ok = 0, e_err = 0, e_start = 0;
   logic [7:0] got_q[$], exp_q[$];
   logic [7:0] m_regs[8] = '{default: 8'h00};

   always #5 clk = ~clk;

   uart_cmd_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn), .rcv(rcv), .data(data), .tx_ready(tx_ready),
      .tx_start(tx_start), .tx_data(tx_data), .regs(regs), .frame_ok(frame_ok), .err(err)
   );

   always @(negedge clk)
      if (rstn) begin
         if (frame_ok) n_ok++;
         if (err) n_err++;
         if (tx_start) begin
            n_start++;
            got_q.push_back(tx_data);
         end
      end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] b);
      rcv = 1'b1;
      data = b;
      tick();
      rcv = 1'b0;
   endtask

   function automatic logic [63:0] model_regs();
      logic [63:0] p;
      for (int k = 0; k < 8; k++) p[8*k +: 8] = m_regs[k];
      return p;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".ok_cnt"}, n_ok, e_ok);
      check({tag, ".err_cnt"}, n_err, e_err);
      check({tag, ".tx_cnt"}, n_start, e_start);
      check({tag, ".regs"}, regs, model_regs());
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      m_regs = '{default: 8'h00};
   endtask

   task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] v,
                        input logic [7:0] c, input int gap, input int hold);
      logic valid;
      logic [7:0] sum;
      sum = 8'((9'h0AA + a + v) % 256);
      valid = c == sum && a < 8;
      tx_ready = hold == 0;
      send(8'hAA); idle(gap);
      send(a);     idle(gap);
      send(v);     idle(gap);
      send(c);
      @(negedge clk);
      check({tag, ".frame_ok"}, frame_ok, valid);
      check({tag, ".err"}, err, !valid);
      if (valid) begin
         m_regs[a[2:0]] = v;
         e_ok++;
      end else e_err++;
      e_start++;
      exp_q.push_back(valid ? 8'h06 : 8'h15);
      if (hold > 0) begin
         idle(hold);
         check({tag, ".held"}, n_start, e_start - 1);
         tx_ready = 1'b1;
      end
      for (int i = 0; i < 50 && n_start < e_start; i++) tick();
      idle(2);
      check_all(tag);
      while (got_q.size() > 0 && exp_q.size() > 0) check({tag, ".resp"}, got_q.pop_front(), exp_q.pop_front());
      check({tag, ".tx_data"}, tx_data, valid ? 8'h06 : 8'h15);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] a, v, c, j;
      idle(3);
      @(negedge clk);
      check("rst.regs", regs, 64'h0);
      check("rst.tx_data", tx_data, 8'h00);
      check("rst.pulses", {tx_start, frame_ok, err}, 3'b000);
      rstn = 1'b1;
      tick();
      frame("valid", 8'h03, 8'h5A, 8'h07, 0, 0);
      frame("bad_chk", 8'h03, 8'h5A, 8'h08, 1, 0);
      frame("bad_addr", 8'h09, 8'h11, 8'hC4, 2, 0);
      send(8'hAA); send(8'h02);
      idle(TO - 1);
      @(negedge clk);
      check("pre_expiry.err_cnt", n_err, e_err);
      idle(10);
      e_err++;
      check_all("timeout");
      frame("after_to", 8'h02, 8'h33, 8'hDF, 0, 0);
      frame("edge_gap", 8'h05, 8'h77, 8'h26, TO - 1, 0);
      tx_ready = 1'b0;
      send(8'h55); idle(2); send(8'h00); idle(2);
      frame("junk", 8'h01, 8'h80, 8'h2B, 0, 50);
      send(8'hAA); send(8'h04);
      do_reset();
      idle(TO + 10);
      check_all("rst_mid");
      tx_ready = 1'b0;
      send(8'hAA); send(8'h06); send(8'h01); send(8'hB1);
      e_ok++;
      idle(3);
      do_reset();
      tx_ready = 1'b1;
      idle(10);
      check_all("rst_resp");
      check("rst_resp.tx_data", tx_data, 8'h00);
      frame("after_rst", 8'h04, 8'hFF, 8'hAD, 0, 0);
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            j = 8'($urandom);
            send(j == 8'hAA ? 8'h55 : j);
            idle(1);
         end
         a = 8'($urandom_range(0, 11));
         v = 8'($urandom);
         c = 8'((9'h0AA + a + v) % 256);
         if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
         frame("rand", a, v, c, $urandom_range(0, 5), $urandom_range(0, 1) == 1 ? $urandom_range(1, 8) : 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
